// File: rtl/ocx_tlx_rcv_credit_sched_pkg.sv
// Shared types and constants for the TLX receive credit return scheduler.
//   VC_CNT_W / DCP_CNT_W : accumulator widths for command and data credits
//   sched_state_e        : scheduler FSM states
//   credit_class_e       : index of each credit class in flag vectors
//   eff_thresh()         : DCP threshold with 0 promoted to 1
package ocx_tlx_credit_pkg;

  localparam int unsigned VC_CNT_W    = 4;
  localparam int unsigned DCP_CNT_W   = 6;
  localparam int unsigned NUM_CLASSES = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } sched_state_e;

  typedef enum logic [1:0] {
    CC_VC0  = 2'd0,
    CC_VC1  = 2'd1,
    CC_DCP0 = 2'd2,
    CC_DCP1 = 2'd3
  } credit_class_e;

  function automatic logic [DCP_CNT_W-1:0] eff_thresh(input logic [DCP_CNT_W-1:0] t);
    return (t == '0) ? DCP_CNT_W'(1) : t;
  endfunction

endpackage

// File: rtl/ocx_tlx_rcv_credit_sched_acc.sv
// Saturating credit accumulator.
//   tlx_clk, reset_n : clock, synchronous active-low reset
//   pulse_i          : one credit returned this cycle
//   snap_i           : batch snapshot taken this cycle; count restarts at pulse_i
//   count_o          : registered credit count
//   nonzero_o/sat_o  : count != 0 / count at all-ones
//   ovf_o            : credit lost this cycle (pulse at saturation, no snapshot)
module ocx_tlx_credit_acc #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             tlx_clk,
  input  logic             reset_n,
  input  logic             pulse_i,
  input  logic             snap_i,
  output logic [WIDTH-1:0] count_o,
  output logic             nonzero_o,
  output logic             sat_o,
  output logic             ovf_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             sat;

  always_comb begin
    sat   = &cnt_q;
    cnt_d = cnt_q;
    if (snap_i) begin
      // The snapshot carries the old count away; this cycle's pulse starts the next batch.
      cnt_d    = '0;
      cnt_d[0] = pulse_i;
    end else if (pulse_i && !sat) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge tlx_clk) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign count_o   = cnt_q;
  assign nonzero_o = |cnt_q;
  assign sat_o     = sat;
  assign ovf_o     = pulse_i & sat & ~snap_i;

endmodule

// File: rtl/ocx_tlx_rcv_credit_sched.sv
// TLX receive credit return scheduler: batches per-class credit pulses and
// hands each batch to the framer over a req/ack handshake.
//   tlx_clk, reset_n          : clock, synchronous active-low reset
//   vc0/vc1/dcp0/dcp1_credit_v: one credit returned per cycle per class
//   cfg_wr, cfg_thresh,
//   cfg_timeout               : config load (thresh 0 acts as 1, timeout 0 disables)
//   credit_ret_req/ack        : batch handshake to the framer
//   credit_ret_vc0/vc1/dcp0/dcp1 : batch counts, stable while req is high
//   credit_ovf_err            : sticky, a credit arrived at a saturated accumulator
module ocx_tlx_rcv_credit_sched
  import ocx_tlx_credit_pkg::*;
#(
  parameter logic [5:0] dflt_thresh  = 6'd8,
  parameter logic [7:0] dflt_timeout = 8'd64
) (
  input  logic       tlx_clk,
  input  logic       reset_n,
  input  logic       vc0_credit_v,
  input  logic       vc1_credit_v,
  input  logic       dcp0_credit_v,
  input  logic       dcp1_credit_v,
  input  logic       cfg_wr,
  input  logic [5:0] cfg_thresh,
  input  logic [7:0] cfg_timeout,
  output logic       credit_ret_req,
  input  logic       credit_ret_ack,
  output logic [3:0] credit_ret_vc0,
  output logic [3:0] credit_ret_vc1,
  output logic [5:0] credit_ret_dcp0,
  output logic [5:0] credit_ret_dcp1,
  output logic       credit_ovf_err
);

  sched_state_e         state_q;
  logic [7:0]           timer_q, timer_d;
  logic [5:0]           thresh_q;
  logic [7:0]           timeout_q;
  logic                 req_q, ovf_q;
  logic [VC_CNT_W-1:0]  ret_vc0_q, ret_vc1_q, acc_vc0, acc_vc1;
  logic [DCP_CNT_W-1:0] ret_dcp0_q, ret_dcp1_q, acc_dcp0, acc_dcp1;
  logic [DCP_CNT_W-1:0] thr_eff;
  logic [NUM_CLASSES-1:0] nz, sat, ovf;
  logic                 trigger;

  ocx_tlx_credit_acc #(.WIDTH(VC_CNT_W)) u_acc_vc0 (
    .tlx_clk(tlx_clk), .reset_n(reset_n), .pulse_i(vc0_credit_v), .snap_i(trigger),
    .count_o(acc_vc0), .nonzero_o(nz[CC_VC0]), .sat_o(sat[CC_VC0]), .ovf_o(ovf[CC_VC0]));

  ocx_tlx_credit_acc #(.WIDTH(VC_CNT_W)) u_acc_vc1 (
    .tlx_clk(tlx_clk), .reset_n(reset_n), .pulse_i(vc1_credit_v), .snap_i(trigger),
    .count_o(acc_vc1), .nonzero_o(nz[CC_VC1]), .sat_o(sat[CC_VC1]), .ovf_o(ovf[CC_VC1]));

  ocx_tlx_credit_acc #(.WIDTH(DCP_CNT_W)) u_acc_dcp0 (
    .tlx_clk(tlx_clk), .reset_n(reset_n), .pulse_i(dcp0_credit_v), .snap_i(trigger),
    .count_o(acc_dcp0), .nonzero_o(nz[CC_DCP0]), .sat_o(sat[CC_DCP0]), .ovf_o(ovf[CC_DCP0]));

  ocx_tlx_credit_acc #(.WIDTH(DCP_CNT_W)) u_acc_dcp1 (
    .tlx_clk(tlx_clk), .reset_n(reset_n), .pulse_i(dcp1_credit_v), .snap_i(trigger),
    .count_o(acc_dcp1), .nonzero_o(nz[CC_DCP1]), .sat_o(sat[CC_DCP1]), .ovf_o(ovf[CC_DCP1]));

  always_comb begin
    thr_eff = eff_thresh(thresh_q);
    trigger = (state_q == ST_IDLE) &&
              ((acc_dcp0 >= thr_eff) || (acc_dcp1 >= thr_eff) || (|sat) ||
               ((timeout_q != '0) && (|nz) && (timer_q == timeout_q)));

    timer_d = timer_q;
    if ((state_q == ST_REQ) || !(|nz) || trigger) timer_d = '0;
    else if (timer_q != '1)                       timer_d = timer_q + 8'd1;
  end

  always_ff @(posedge tlx_clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      req_q      <= 1'b0;
      ret_vc0_q  <= '0;
      ret_vc1_q  <= '0;
      ret_dcp0_q <= '0;
      ret_dcp1_q <= '0;
      ovf_q      <= 1'b0;
      timer_q    <= '0;
      thresh_q   <= dflt_thresh;
      timeout_q  <= dflt_timeout;
    end else begin
      timer_q <= timer_d;
      ovf_q   <= ovf_q | (|ovf);
      if (cfg_wr) begin
        thresh_q  <= cfg_thresh;
        timeout_q <= cfg_timeout;
      end
      case (state_q)
        ST_IDLE: begin
          if (trigger) begin
            ret_vc0_q  <= acc_vc0;
            ret_vc1_q  <= acc_vc1;
            ret_dcp0_q <= acc_dcp0;
            ret_dcp1_q <= acc_dcp1;
            req_q      <= 1'b1;
            state_q    <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (credit_ret_ack) begin
            req_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign credit_ret_req  = req_q;
  assign credit_ret_vc0  = ret_vc0_q;
  assign credit_ret_vc1  = ret_vc1_q;
  assign credit_ret_dcp0 = ret_dcp0_q;
  assign credit_ret_dcp1 = ret_dcp1_q;
  assign credit_ovf_err  = ovf_q;

endmodule
